// File: rtl/matmul_host_sequencer.sv
// Host-side sequencer for the 8x8 matmul block: loads A/B words,
// starts the multiply, then drains C words over a valid/ready stream.
module matmul_host_sequencer #(
    parameter int DWIDTH      = 16,
    parameter int BB_SIZE     = 4,
    parameter int AWIDTH      = 7,
    parameter int A_WORDS     = 8,
    parameter int B_WORDS     = 8,
    parameter int C_WORDS     = 8,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_start,
    output logic                      cmd_busy,
    output logic                      cmd_done,
    output logic                      cmd_error,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BB_SIZE*DWIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BB_SIZE*DWIDTH-1:0] out_data,
    output logic                      mm_enable_writing_to_mem,
    output logic                      mm_enable_reading_from_mem,
    output logic [AWIDTH-1:0]         mm_addr_pi,
    output logic [BB_SIZE*DWIDTH-1:0] mm_data_pi,
    output logic                      mm_we_a,
    output logic                      mm_we_b,
    output logic                      mm_we_c,
    output logic                      mm_start_mat_mul,
    input  logic                      mm_done_mat_mul,
    input  logic [BB_SIZE*DWIDTH-1:0] mm_data_from_out_mat
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_FLUSH,
        S_COMPUTE,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RD_OUT,
        S_FIN,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AWIDTH-1:0] r_ptr;
    logic [AWIDTH-1:0] w_ptr_nxt;
    logic [TW-1:0]     r_tmo;
    logic [TW-1:0]     w_tmo_nxt;
    logic              w_in_hs;
    logic              w_out_hs;

    assign w_in_hs  = in_valid && in_ready;
    assign w_out_hs = out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_tmo_nxt   = r_tmo;
        unique case (r_state)
            S_IDLE: begin
                if (cmd_start) begin
                    w_state_nxt = S_LOAD_A;
                    w_ptr_nxt   = '0;
                end
            end
            S_LOAD_A: begin
                if (w_in_hs) begin
                    if (r_ptr == AWIDTH'(A_WORDS - 1)) begin
                        w_state_nxt = S_LOAD_B;
                        w_ptr_nxt   = '0;
                    end else begin
                        w_ptr_nxt = r_ptr + 1'b1;
                    end
                end
            end
            S_LOAD_B: begin
                if (w_in_hs) begin
                    if (r_ptr == AWIDTH'(B_WORDS - 1)) begin
                        w_state_nxt = S_FLUSH;
                        w_ptr_nxt   = '0;
                    end else begin
                        w_ptr_nxt = r_ptr + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_COMPUTE;
                w_tmo_nxt   = '0;
            end
            S_COMPUTE: begin
                if (r_tmo != TW'(TIMEOUT_CYC)) begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
                // done has priority over an expiring timeout
                if (mm_done_mat_mul) begin
                    w_state_nxt = S_RD_ADDR;
                    w_ptr_nxt   = '0;
                end else if (r_tmo == TW'(TIMEOUT_CYC)) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_RD_ADDR: w_state_nxt = S_RD_WAIT;
            S_RD_WAIT: w_state_nxt = S_RD_OUT;
            S_RD_OUT: begin
                if (w_out_hs) begin
                    if (r_ptr == AWIDTH'(C_WORDS - 1)) begin
                        w_state_nxt = S_FIN;
                        w_ptr_nxt   = '0;
                    end else begin
                        w_state_nxt = S_RD_ADDR;
                        w_ptr_nxt   = r_ptr + 1'b1;
                    end
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state                    <= S_IDLE;
            r_ptr                      <= '0;
            r_tmo                      <= '0;
            cmd_busy                   <= 1'b0;
            cmd_done                   <= 1'b0;
            cmd_error                  <= 1'b0;
            in_ready                   <= 1'b0;
            out_valid                  <= 1'b0;
            out_data                   <= '0;
            mm_enable_writing_to_mem   <= 1'b0;
            mm_enable_reading_from_mem <= 1'b0;
            mm_addr_pi                 <= '0;
            mm_data_pi                 <= '0;
            mm_we_a                    <= 1'b0;
            mm_we_b                    <= 1'b0;
            mm_we_c                    <= 1'b0;
            mm_start_mat_mul           <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_tmo     <= w_tmo_nxt;
            cmd_busy  <= (w_state_nxt != S_IDLE);
            cmd_done  <= (w_state_nxt == S_FIN);
            cmd_error <= (w_state_nxt == S_ERR);
            in_ready  <= (w_state_nxt == S_LOAD_A) ||
                         (w_state_nxt == S_LOAD_B);
            out_valid <= (w_state_nxt == S_RD_OUT);
            // FLUSH keeps the write enable up for the last B write
            mm_enable_writing_to_mem <= (w_state_nxt == S_LOAD_A) ||
                                        (w_state_nxt == S_LOAD_B) ||
                                        (w_state_nxt == S_FLUSH);
            mm_enable_reading_from_mem <= (w_state_nxt == S_RD_ADDR) ||
                                          (w_state_nxt == S_RD_WAIT) ||
                                          (w_state_nxt == S_RD_OUT);
            mm_start_mat_mul <= (w_state_nxt == S_COMPUTE);
            mm_we_c          <= (w_state_nxt == S_COMPUTE);
            mm_we_a          <= (r_state == S_LOAD_A) && w_in_hs;
            mm_we_b          <= (r_state == S_LOAD_B) && w_in_hs;
            if (w_in_hs) begin
                mm_addr_pi <= r_ptr;
                mm_data_pi <= in_data;
            end else if (w_state_nxt == S_RD_ADDR) begin
                mm_addr_pi <= w_ptr_nxt;
            end
            if (r_state == S_RD_WAIT) begin
                out_data <= mm_data_from_out_mat;
            end
        end
    end

endmodule

// File: tb/tb_matmul_host_sequencer.sv
// Directed bench for matmul_host_sequencer with a behavioural matmul
// stand-in and a per-cycle scoreboard on writes and drained C words.
module tb_matmul_host_sequencer;

    localparam int WW  = 64;
    localparam int TMO = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_start;
    logic          cmd_busy, cmd_done, cmd_error;
    logic          in_valid, in_ready;
    logic [WW-1:0] in_data;
    logic          out_valid, out_ready;
    logic [WW-1:0] out_data;
    logic          ewr, erd;
    logic [6:0]    mm_addr_pi;
    logic [WW-1:0] mm_data_pi;
    logic          we_a, we_b, we_c, mm_start;
    logic          mm_done;
    logic [WW-1:0] mm_rdata;

    matmul_host_sequencer #(.TIMEOUT_CYC(TMO)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .cmd_start                  (cmd_start),
        .cmd_busy                   (cmd_busy),
        .cmd_done                   (cmd_done),
        .cmd_error                  (cmd_error),
        .in_valid                   (in_valid),
        .in_ready                   (in_ready),
        .in_data                    (in_data),
        .out_valid                  (out_valid),
        .out_ready                  (out_ready),
        .out_data                   (out_data),
        .mm_enable_writing_to_mem   (ewr),
        .mm_enable_reading_from_mem (erd),
        .mm_addr_pi                 (mm_addr_pi),
        .mm_data_pi                 (mm_data_pi),
        .mm_we_a                    (we_a),
        .mm_we_b                    (we_b),
        .mm_we_c                    (we_c),
        .mm_start_mat_mul           (mm_start),
        .mm_done_mat_mul            (mm_done),
        .mm_data_from_out_mat       (mm_rdata)
    );

    always #5 clk = ~clk;

    // C word = lane-wise 16-bit product of A word and B word
    function automatic logic [WW-1:0] cword(input logic [WW-1:0] a,
                                            input logic [WW-1:0] b);
        logic [WW-1:0] r;
        r = '0;
        for (int e = 0; e < 4; e++) r[e*16 +: 16] = a[e*16 +: 16] * b[e*16 +: 16];
        return r;
    endfunction

    int            lat;
    bit            no_done;
    int            mcnt;
    logic [WW-1:0] amem[8];
    logic [WW-1:0] bmem[8];
    logic [WW-1:0] cmem[8];

    always_ff @(posedge clk) begin
        if (we_a) amem[mm_addr_pi[2:0]] <= mm_data_pi;
        if (we_b) bmem[mm_addr_pi[2:0]] <= mm_data_pi;
        mm_rdata <= cmem[mm_addr_pi[2:0]];
        mcnt     <= mm_start ? mcnt + 1 : 0;
        mm_done  <= mm_start && !no_done && (mcnt == lat);
        if (mm_start && mcnt == lat)
            for (int k = 0; k < 8; k++) cmem[k] <= cword(amem[k], bmem[k]);
    end

    int            ncmp, nbad;
    logic [WW-1:0] a_w[8];
    logic [WW-1:0] b_w[8];
    logic [WW-1:0] exp_c[8];
    int            stall_mode;
    int            wi, ci, cyc, last_hs_cyc, done_cnt, err_cnt, last_ci, last_wi;
    bit            prev_stall;
    logic [WW-1:0] prev_data, last_out;

    task automatic chk(input string nm, input logic [WW-1:0] got,
                       input logic [WW-1:0] exp);
        ncmp++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic monitor_cycle;
        cyc++;
        if (reset) begin
            wi = 0; ci = 0; prev_stall = 0;
            return;
        end
        if (ewr || erd) chk("wr_rd_excl", WW'(ewr & erd), 0);
        if (we_a || we_b || we_c)
            chk("we_onehot", WW'($countones({we_a, we_b, we_c}) <= 1), 1);
        if (we_a || we_b) begin
            if (wi < 16) begin
                chk("we_kind", WW'({we_a, we_b}), (wi < 8) ? 2'b10 : 2'b01);
                chk("we_addr", WW'(mm_addr_pi), WW'(wi % 8));
                chk("we_data", mm_data_pi, (wi < 8) ? a_w[wi] : b_w[wi-8]);
            end else begin
                chk("we_extra", WW'(wi), 15);
            end
            wi++;
        end
        if (prev_stall) begin
            chk("out_hold_valid", WW'(out_valid), 1);
            chk("out_hold_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
            if (ci < 8) chk("c_word", out_data, exp_c[ci]);
            else        chk("c_extra", WW'(ci), 7);
            if (stall_mode == 0 && ci > 0) chk("c_gap", WW'(cyc - last_hs_cyc), 3);
            last_hs_cyc = cyc;
            last_out    = out_data;
            ci++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (cmd_done || cmd_error) begin
            if (cmd_done) done_cnt++;
            else          err_cnt++;
            last_ci = ci; last_wi = wi; ci = 0; wi = 0;
        end
    endtask

    task automatic do_reset(input int d0, input int e0);
        #2 reset = 1'b1;
        #1;
        chk("reset_outs_zero", WW'(|{cmd_busy, cmd_done, cmd_error, in_ready,
            out_valid, out_data, ewr, erd, mm_addr_pi, mm_data_pi,
            we_a, we_b, we_c, mm_start}), 0);
        in_valid = 0; out_ready = 0; cmd_start = 0;
        step;
        reset = 1'b0;
        repeat (4) step;
        chk("abort_no_done", WW'(done_cnt - d0), 0);
        chk("abort_no_err", WW'(err_cnt - e0), 0);
        chk("abort_idle", WW'(cmd_busy), 0);
    endtask

    task automatic run_job(input int gap, input int stall, input bit poke,
                           input int l, input bit nodone, input int abort_at);
        int d0, e0, t, ts;
        bit hs;
        d0 = done_cnt; e0 = err_cnt;
        lat = l; no_done = nodone; stall_mode = stall;
        for (int k = 0; k < 8; k++) exp_c[k] = cword(a_w[k], b_w[k]);
        out_ready = (stall == 0);
        cmd_start = 1'b1;
        step;
        cmd_start = 1'b0;
        chk("busy_after_start", WW'(cmd_busy), 1);
        for (int w = 0; w < 16; w++) begin
            in_valid = 0;
            repeat (gap) step;
            in_valid = 1;
            in_data  = (w < 8) ? a_w[w] : b_w[w-8];
            if (poke && w == 10) cmd_start = 1'b1;
            t = 0;
            do begin
                hs = in_ready;
                step;
                cmd_start = 1'b0;
                t++;
            end while (!hs && t < 200);
            if (!hs) begin
                chk("load_timeout", 0, 1);
                break;
            end
        end
        in_valid = 0;
        in_data  = '0;
        chk("in_ready_low_after_load", WW'(in_ready), 0);
        t = 0;
        while (!mm_start && t < 100) begin step; t++; end
        if (abort_at == 1) begin
            repeat (3) step;
            do_reset(d0, e0);
            return;
        end
        if (nodone) begin
            ts = 0;
            while (!cmd_error && ts < 100) begin step; ts++; end
            chk("err_latency", WW'(ts), TMO + 1);
            chk("start_low_at_err", WW'(mm_start), 0);
            step;
            chk("idle_after_err", WW'(cmd_busy), 0);
            chk("err_once", WW'(err_cnt - e0), 1);
            chk("err_no_done", WW'(done_cnt - d0), 0);
            chk("err_no_out", WW'(last_ci), 0);
            return;
        end
        if (stall > 0) begin
            for (int k = 0; k < 8; k++) begin
                t = 0;
                while (!out_valid && t < 100) begin step; t++; end
                if (!out_valid) begin
                    chk("drain_timeout", 0, 1);
                    break;
                end
                if (abort_at == 2 && k == 2) begin
                    do_reset(d0, e0);
                    return;
                end
                for (int s = 0; s < stall; s++) begin
                    if (poke && k == 3 && s == 0) cmd_start = 1'b1;
                    step;
                    cmd_start = 1'b0;
                end
                out_ready = 1;
                step;
                out_ready = 0;
            end
        end
        t = 0;
        while (done_cnt == d0 && t < 500) begin step; t++; end
        step;
        chk("done_once", WW'(done_cnt - d0), 1);
        chk("no_error", WW'(err_cnt - e0), 0);
        chk("c_count", WW'(last_ci), 8);
        chk("w_count", WW'(last_wi), 16);
        chk("idle_after_done", WW'(cmd_busy), 0);
    endtask

    task automatic rand_words;
        for (int k = 0; k < 8; k++) begin
            a_w[k] = {$urandom, $urandom};
            b_w[k] = {$urandom, $urandom};
        end
    endtask

    initial begin
        ncmp = 0; nbad = 0; wi = 0; ci = 0; cyc = 0; last_hs_cyc = 0;
        done_cnt = 0; err_cnt = 0; last_ci = 0; last_wi = 0;
        prev_stall = 0; prev_data = '0; last_out = '0;
        stall_mode = 0; lat = 5; no_done = 0;
        reset = 1'b1; cmd_start = 0; in_valid = 0; in_data = '0; out_ready = 0;
        fork
            forever begin
                @(negedge clk);
                monitor_cycle();
            end
            begin
                #3;
                chk("reset_state", WW'(|{cmd_busy, cmd_done, cmd_error, in_ready,
                    out_valid, ewr, erd, we_a, we_b, we_c, mm_start}), 0);
                step;
                reset = 1'b0;
                step;
                chk("pin_cword_ones", cword({4{16'h1}}, {4{16'd3}}),
                    64'h0003_0003_0003_0003);
                chk("pin_cword_mul", cword({4{16'd2}}, {4{16'd7}}),
                    64'h000e_000e_000e_000e);
                for (int k = 0; k < 8; k++) begin
                    a_w[k] = {4{16'h1}};
                    b_w[k] = {4{16'(k)}};
                end
                run_job(0, 0, 0, 5, 0, 0);
                chk("c7_literal", last_out, 64'h0007_0007_0007_0007);
                rand_words();
                run_job(2, 0, 0, TMO - 1, 0, 0);
                rand_words();
                run_job(0, 5, 0, 3, 0, 0);
                rand_words();
                run_job(0, 0, 0, 0, 1, 0);
                rand_words();
                run_job(0, 0, 0, 6, 0, 1);
                run_job(1, 0, 0, 4, 0, 0);
                rand_words();
                run_job(0, 5, 0, 4, 0, 2);
                run_job(0, 0, 0, 4, 0, 0);
                rand_words();
                run_job(0, 5, 1, 4, 0, 0);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
                $finish;
            end
        join_any
    end

endmodule
